// File: rtl/alu_bist.sv
// ---------------------------------------------------------------------------
// alu_bist -- built-in self-test sequencer for the 4-bit combinational ALU.
//
// Drives pseudo-random operand pairs from an 8-bit LFSR and walks the select
// code with the vector index. It samples the ALU result SETTLE cycles after
// driving and compares it with an internal golden model. It reports a
// one-cycle done pulse, a pass flag and a saturating mismatch count.
//
// Parameters:
//   NUM_VECTORS  vectors per run (1..1024)
//   SETTLE       cycles between driving operands and sampling (1..15)
//   SEED         nonzero LFSR load value
//
// Ports:
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   start        run request, honoured only while idle
//   alu_a/alu_b  registered operands to the ALU
//   alu_sel      registered operation select to the ALU
//   alu_result   ALU result under test
//   busy         run in progress (start accepted .. DONE left)
//   done         one-cycle end-of-run pulse
//   pass         last run had zero mismatches (valid from done onward)
//   err_count    mismatch count, saturating at 255
//
// Optional feature (macro ALU_BIST_FAIL_CAPTURE_EN):
//   fail_valid, fail_a, fail_b, fail_sel, fail_result hold the first
//   mismatching vector of a run together with the received result.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module alu_bist #(
   parameter int unsigned NUM_VECTORS = 64,
   parameter int unsigned SETTLE      = 1,
   parameter logic [7:0]  SEED        = 8'hA5
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   output logic [3:0] alu_a,
   output logic [3:0] alu_b,
   output logic [2:0] alu_sel,
   input  logic [3:0] alu_result,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [7:0] err_count
`ifdef ALU_BIST_FAIL_CAPTURE_EN
   ,
   output logic       fail_valid,
   output logic [3:0] fail_a,
   output logic [3:0] fail_b,
   output logic [2:0] fail_sel,
   output logic [3:0] fail_result
`endif
);

   localparam logic [9:0] LAST_IDX  = 10'(NUM_VECTORS - 1);
   localparam logic [3:0] SETTLE_LD = 4'(SETTLE);

   typedef enum logic [2:0] {
      S_IDLE,
      S_DRIVE,
      S_WAIT,
      S_CHECK,
      S_DONE
   } state_t;

   state_t     r_state;
   logic [7:0] r_lfsr;
   logic [9:0] r_idx;
   logic [3:0] r_settle;
   logic [3:0] r_alu_a;
   logic [3:0] r_alu_b;
   logic [2:0] r_alu_sel;
   logic       r_busy;
   logic       r_done;
   logic       r_pass;
   logic [7:0] r_err;

`ifdef ALU_BIST_FAIL_CAPTURE_EN
   logic       r_fail_valid;
   logic [3:0] r_fail_a;
   logic [3:0] r_fail_b;
   logic [2:0] r_fail_sel;
   logic [3:0] r_fail_result;
`endif

   logic [3:0] w_gold;
   logic       w_mismatch;
   logic [7:0] w_err_next;
   logic [7:0] w_lfsr_next;

   // Golden result from the registered operands the ALU is currently seeing.
   always_comb begin
      w_gold = '0;
      case (r_alu_sel)
         3'd0:    w_gold = r_alu_a + r_alu_b;
         3'd1:    w_gold = r_alu_a - r_alu_b;
         3'd2:    w_gold = r_alu_a & r_alu_b;
         3'd3:    w_gold = r_alu_a | r_alu_b;
         3'd4:    w_gold = ~r_alu_a;
         default: w_gold = '0;
      endcase
   end

   assign w_mismatch  = (alu_result != w_gold);
   // Count saturates at 255 so a badly broken ALU cannot wrap back to "pass".
   assign w_err_next  = (w_mismatch && (r_err != 8'hFF)) ? r_err + 8'd1 : r_err;
   assign w_lfsr_next = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_lfsr    <= SEED;
         r_idx     <= '0;
         r_settle  <= '0;
         r_alu_a   <= '0;
         r_alu_b   <= '0;
         r_alu_sel <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_pass    <= 1'b0;
         r_err     <= '0;
`ifdef ALU_BIST_FAIL_CAPTURE_EN
         r_fail_valid  <= 1'b0;
         r_fail_a      <= '0;
         r_fail_b      <= '0;
         r_fail_sel    <= '0;
         r_fail_result <= '0;
`endif
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_alu_a   <= '0;
               r_alu_b   <= '0;
               r_alu_sel <= '0;
               if (start) begin
                  r_lfsr  <= SEED;
                  r_idx   <= '0;
                  r_err   <= '0;
                  r_pass  <= 1'b0;
                  r_busy  <= 1'b1;
`ifdef ALU_BIST_FAIL_CAPTURE_EN
                  r_fail_valid  <= 1'b0;
                  r_fail_a      <= '0;
                  r_fail_b      <= '0;
                  r_fail_sel    <= '0;
                  r_fail_result <= '0;
`endif
                  r_state <= S_DRIVE;
               end
            end
            S_DRIVE: begin
               r_alu_a   <= r_lfsr[7:4];
               r_alu_b   <= r_lfsr[3:0];
               r_alu_sel <= r_idx[2:0];
               r_settle  <= SETTLE_LD;
               r_state   <= S_WAIT;
            end
            S_WAIT: begin
               // Leaving on the count of 1 gives exactly SETTLE wait cycles.
               r_settle <= r_settle - 4'd1;
               if (r_settle <= 4'd1) begin
                  r_state <= S_CHECK;
               end
            end
            S_CHECK: begin
               r_err <= w_err_next;
`ifdef ALU_BIST_FAIL_CAPTURE_EN
               if (w_mismatch && !r_fail_valid) begin
                  r_fail_valid  <= 1'b1;
                  r_fail_a      <= r_alu_a;
                  r_fail_b      <= r_alu_b;
                  r_fail_sel    <= r_alu_sel;
                  r_fail_result <= alu_result;
               end
`endif
               if (r_idx == LAST_IDX) begin
                  // Use the post-update count so the final vector is included.
                  r_pass  <= (w_err_next == '0);
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  r_idx   <= r_idx + 10'd1;
                  r_lfsr  <= w_lfsr_next;
                  r_state <= S_DRIVE;
               end
            end
            S_DONE: begin
               r_busy    <= 1'b0;
               r_alu_a   <= '0;
               r_alu_b   <= '0;
               r_alu_sel <= '0;
               r_state   <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign alu_a     = r_alu_a;
   assign alu_b     = r_alu_b;
   assign alu_sel   = r_alu_sel;
   assign busy      = r_busy;
   assign done      = r_done;
   assign pass      = r_pass;
   assign err_count = r_err;

`ifdef ALU_BIST_FAIL_CAPTURE_EN
   assign fail_valid  = r_fail_valid;
   assign fail_a      = r_fail_a;
   assign fail_b      = r_fail_b;
   assign fail_sel    = r_fail_sel;
   assign fail_result = r_fail_result;
`endif

endmodule

// File: tb/tb_alu_bist.sv
`timescale 1ns/1ps

module tb_alu_bist;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // Three sequencers with different geometries share clock and reset.
   int   nvec   [3] = '{16, 8, 300};
   int   settle [3] = '{1, 4, 1};

   logic       start [3];
   logic [3:0] a     [3];
   logic [3:0] b     [3];
   logic [2:0] sel   [3];
   logic [3:0] res   [3];
   logic       busy  [3];
   logic       done  [3];
   logic       pass  [3];
   logic [7:0] errc  [3];
`ifdef ALU_BIST_FAIL_CAPTURE_EN
   logic       fv [3];
   logic [3:0] fa [3];
   logic [3:0] fb [3];
   logic [2:0] fs [3];
   logic [3:0] fr [3];
`endif

   // ALU model behaviour per unit: 0 correct, 1 returns A for sel=100,
   // 2 correct result XORed with a per-select corruption mask.
   int         mode [3];
   logic [3:0] xtab [3][8];

   alu_bist #(.NUM_VECTORS(16), .SETTLE(1), .SEED(8'hA5)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .start(start[0]), .alu_a(a[0]), .alu_b(b[0]),
      .alu_sel(sel[0]), .alu_result(res[0]), .busy(busy[0]), .done(done[0]),
      .pass(pass[0]), .err_count(errc[0])
`ifdef ALU_BIST_FAIL_CAPTURE_EN
      , .fail_valid(fv[0]), .fail_a(fa[0]), .fail_b(fb[0]), .fail_sel(fs[0]), .fail_result(fr[0])
`endif
   );

   alu_bist #(.NUM_VECTORS(8), .SETTLE(4), .SEED(8'hA5)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start[1]), .alu_a(a[1]), .alu_b(b[1]),
      .alu_sel(sel[1]), .alu_result(res[1]), .busy(busy[1]), .done(done[1]),
      .pass(pass[1]), .err_count(errc[1])
`ifdef ALU_BIST_FAIL_CAPTURE_EN
      , .fail_valid(fv[1]), .fail_a(fa[1]), .fail_b(fb[1]), .fail_sel(fs[1]), .fail_result(fr[1])
`endif
   );

   alu_bist #(.NUM_VECTORS(300), .SETTLE(1), .SEED(8'hA5)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .start(start[2]), .alu_a(a[2]), .alu_b(b[2]),
      .alu_sel(sel[2]), .alu_result(res[2]), .busy(busy[2]), .done(done[2]),
      .pass(pass[2]), .err_count(errc[2])
`ifdef ALU_BIST_FAIL_CAPTURE_EN
      , .fail_valid(fv[2]), .fail_a(fa[2]), .fail_b(fb[2]), .fail_sel(fs[2]), .fail_result(fr[2])
`endif
   );

   function automatic logic [3:0] gold(input logic [3:0] x, input logic [3:0] y, input logic [2:0] s);
      case (s)
         3'd0:    return x + y;
         3'd1:    return x - y;
         3'd2:    return x & y;
         3'd3:    return x | y;
         3'd4:    return ~x;
         default: return 4'h0;
      endcase
   endfunction

   function automatic logic [7:0] lfsr_step(input logic [7:0] v);
      return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
   endfunction

   always_comb begin
      for (int u = 0; u < 3; u++) begin
         res[u] = gold(a[u], b[u], sel[u]);
         if (mode[u] == 1 && sel[u] == 3'd4) res[u] = a[u];
         else if (mode[u] == 2) res[u] = gold(a[u], b[u], sel[u]) ^ xtab[u][sel[u]];
      end
   end

   // Record each distinct vector presented while the unit under test is busy.
   int          cur = 0;
   logic [10:0] prev = '0;
   logic [10:0] vq [$];
   always @(negedge clk) begin
      logic [10:0] t;
      t = {a[cur], b[cur], sel[cur]};
      if (busy[cur] && t != prev) vq.push_back(t);
      prev = t;
   end

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
      else n_pass++;
   endtask

   task automatic run_chk(input int u, input int exp_k, input int exp_err, input bit exp_pass, input bit repulse);
      int k;
      int first_k;
      int ndone;
      int nbad;
      int first_bad;
      logic [7:0] lf;
      logic [10:0] ev;
      @(posedge clk);
      #1;
      cur = u;
      vq.delete();
      prev = {a[u], b[u], sel[u]};
      start[u] = 1'b1;
      @(posedge clk);                   // edge 0 accepts start
      #1 start[u] = 1'b0;
      @(negedge clk);
      chk("busy_rise", busy[u], 1);
      chk("err_clear", errc[u], 0);
      chk("pass_clear", pass[u], 0);
      k = 0;
      first_k = -1;
      ndone = 0;
      while (k < exp_k + 6) begin
         @(posedge clk);
         #1;
         k++;
         // One request mid-run and one on the edge leaving DONE; both must be ignored.
         start[u] = repulse && (k == 4 || k == exp_k);
         @(negedge clk);
         if (k == 1) chk("first_vec", {a[u], b[u], sel[u]}, {4'hA, 4'h5, 3'd0});
         if (done[u]) begin
            ndone++;
            if (first_k < 0) first_k = k;
         end
         if (k == exp_k) chk("busy_in_done", busy[u], 1);
         if (k == exp_k + 1) chk("busy_fall", busy[u], 0);
      end
      start[u] = 1'b0;
      chk("done_cycle", first_k + 1, exp_k + 1);
      chk("done_pulses", ndone, 1);
      chk("busy_idle", busy[u], 0);
      chk("err_count", errc[u], exp_err);
      chk("pass", pass[u], int'(exp_pass));
      chk("alu_idle_zero", {a[u], b[u], sel[u]}, 0);
      chk("vec_count", vq.size(), nvec[u]);
      lf = 8'hA5;
      nbad = 0;
      first_bad = -1;
      for (int i = 0; i < nvec[u]; i++) begin
         ev = {lf[7:4], lf[3:0], 3'(i)};
         if (i >= vq.size() || vq[i] != ev) begin
            nbad++;
            if (first_bad < 0) first_bad = i;
         end
         lf = lfsr_step(lf);
      end
      chk("vec_seq_bad_first", first_bad, -1);
   endtask

   typedef struct {
      int  u;
      int  mode;
      bit  repulse;
      int  exp_k;
      int  exp_err;
      bit  exp_pass;
   } row_t;

   row_t rows [5];

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int exp_err;
      int u;
      rows[0] = '{0, 0, 1'b1, 48,  0,   1'b1};
      rows[1] = '{0, 1, 1'b0, 48,  2,   1'b0};
      rows[2] = '{2, 2, 1'b0, 900, 255, 1'b0};
      rows[3] = '{1, 1, 1'b0, 48,  1,   1'b0};
      rows[4] = '{1, 0, 1'b1, 48,  0,   1'b1};

      for (int i = 0; i < 3; i++) begin
         start[i] = 1'b0;
         mode[i] = 0;
         for (int s = 0; s < 8; s++) xtab[i][s] = 4'h0;
      end

      repeat (3) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         chk("reset_alu", {a[i], b[i], sel[i]}, 0);
         chk("reset_flags", {busy[i], done[i], pass[i], errc[i]}, 0);
      end
      rst_n = 1'b1;

      for (int r = 0; r < 5; r++) begin
         mode[rows[r].u] = rows[r].mode;
         for (int s = 0; s < 8; s++) xtab[rows[r].u][s] = 4'hF;
         run_chk(rows[r].u, rows[r].exp_k, rows[r].exp_err, rows[r].exp_pass, rows[r].repulse);
`ifdef ALU_BIST_FAIL_CAPTURE_EN
         if (r == 1) begin
            chk("fail_valid", fv[0], 1);
            chk("fail_sel", fs[0], 4);
            chk("fail_result", fr[0], fa[0]);
         end
`endif
      end

      // Reset in the middle of a run with one mismatch already counted.
      chk("u1_pass_before_reset", pass[1], 1);
      mode[0] = 1;
      @(posedge clk);
      #1 start[0] = 1'b1;
      @(posedge clk);
      #1 start[0] = 1'b0;
      repeat (20) @(posedge clk);
      @(negedge clk);
      chk("midrun_busy", busy[0], 1);
      chk("midrun_err", errc[0], 1);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_alu", {a[0], b[0], sel[0]}, 0);
      chk("abort_flags", {busy[0], done[0], pass[0], errc[0]}, 0);
      chk("abort_u1_pass", pass[1], 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("no_resume", busy[0], 0);
      mode[0] = 0;
      run_chk(0, 48, 0, 1'b1, 1'b0);

      // Random corruption masks per select code; expected count from the masks.
      for (int rr = 0; rr < 6; rr++) begin
         u = rr % 2;
         mode[u] = 2;
         for (int s = 0; s < 8; s++)
            xtab[u][s] = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
         exp_err = 0;
         for (int i = 0; i < nvec[u]; i++)
            if (xtab[u][i % 8] != 4'h0) exp_err++;
         if (exp_err > 255) exp_err = 255;
         repeat ($urandom_range(0, 3)) @(posedge clk);
         run_chk(u, nvec[u] * (settle[u] + 2), exp_err, exp_err == 0, 1'b0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/alu_bist.md
# alu_bist

Built-in self-test sequencer for the 4-bit combinational ALU. It is the initiator on the ALU's operand/select interface: it generates pseudo-random operand pairs, cycles through every select code, samples the ALU result after a configurable settle time, and checks it against an internal golden model. It sits beside the ALU in the datapath and reports pass/fail and an error count to the system controller.

## Interface
Parameters:
- NUM_VECTORS, 64, number of vectors per run; legal range 1..1024.
- SETTLE, 1, cycles between driving operands and sampling the result; legal range 1..15.
- SEED, 8'hA5, LFSR load value at start; must be nonzero.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  run request; sampled only in IDLE.
- alu_a  out  4  operand A to the ALU; registered.
- alu_b  out  4  operand B to the ALU; registered.
- alu_sel  out  3  operation select to the ALU; registered.
- alu_result  in  4  ALU result.
- busy  out  1  high from the cycle after start is accepted until DONE is left.
- done  out  1  one-cycle pulse at the end of a run.
- pass  out  1  1 when the last run had zero mismatches; valid from done onward.
- err_count  out  8  mismatch count for the current or last run; saturates at 255.

## Operation
- Golden model, all results modulo 16:
  - 000: A+B.
  - 001: A−B.
  - 010: A&B.
  - 011: A|B.
  - 100: ~A.
  - 101, 110, 111: 4'b0000.
- LFSR: 8 bits, loaded with SEED on start. Advance rule: next = {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}. The LFSR advances once per vector, after CHECK.
- Vector fields: alu_a = lfsr[7:4], alu_b = lfsr[3:0], alu_sel = idx[2:0], where idx is the 10-bit vector index starting at 0.
- FSM states: IDLE, DRIVE, WAIT, CHECK, DONE.
  - IDLE: alu_* held at 0. When start=1: load the LFSR, clear idx, err_count and pass, then go to DRIVE.
  - DRIVE: register alu_a, alu_b and alu_sel from the LFSR and idx; load settle counter with SETTLE; go to WAIT.
  - WAIT: decrement the settle counter; on reaching 0, go to CHECK.
  - CHECK: compare alu_result with the golden result computed from the registered alu_*. On mismatch, increment err_count, saturating at 255. If idx = NUM_VECTORS−1, go to DONE; otherwise increment idx, advance the LFSR and go to DRIVE.
  - DONE: done=1 and pass=(err_count==0) for exactly one cycle; then go to IDLE. pass holds until the next accepted start.
- start outside IDLE is ignored; it is not queued.

## Timing
- Reset values: alu_a=0, alu_b=0, alu_sel=0, busy=0, done=0, pass=0, err_count=0; FSM in IDLE; LFSR=SEED.
- Reset mid-run aborts immediately to the reset values; no done pulse is generated.
- Each vector takes SETTLE+2 cycles (DRIVE, SETTLE×WAIT, CHECK).
- With start sampled at edge 0, done is high in cycle NUM_VECTORS×(SETTLE+2)+1.
- busy rises on the edge that accepts start and falls on the edge leaving DONE.
- err_count updates on the edge after a CHECK cycle; pass is updated on entry to DONE.

## Configuration
- ALU_BIST_FAIL_CAPTURE_EN defined:
  - Adds outputs fail_valid (1), fail_a (4), fail_b (4), fail_sel (3) and fail_result (4).
  - These capture the first mismatching vector of a run and the received result.
  - All of them reset to 0 and are cleared on an accepted start.
  - fail_valid is held high until the next start or reset.
- Undefined: these ports and their registers do not exist; all other behaviour is identical.

## Test plan
- Correct ALU model, NUM_VECTORS=16, SETTLE=1, start pulsed at cycle 0 -> first vector alu_a=1010, alu_b=0101, alu_sel=000 with expected 1111; done in cycle 49; pass=1; err_count=0.
- ALU model returning A for sel=100 (instead of ~A), NUM_VECTORS=16 -> err_count=2, pass=0. With the macro defined: fail_sel=100, fail_result=fail_a.
- Correct ALU, SETTLE=4, NUM_VECTORS=8 -> done in cycle 8×6+1=49. Check vectors with sel=101/110/111 expect 0000, and A−B wraps modulo 16 (e.g. 0010−0101=1101).
- ALU model with inverted result, NUM_VECTORS=300 -> err_count saturates at 255; pass=0.
- Start re-pulsed while busy -> ignored; done fires once at the original cycle.
- rst_n low mid-run -> all outputs immediately 0 and FSM in IDLE; a new start re-runs from SEED and reproduces the first vector exactly.
